// File: rtl/oserdes_stream_tx.sv
// Multi-lane output serializer for the SdramXdr PHY test models.
// Parallel words arrive on a valid/ready interface and wait in a holding
// register. They move into a shifter that emits one bit per lane per CLK
// cycle. The holding register refills on the edge where the shifter loads,
// so back-to-back words stream with no idle cycle between them.
// A gap that follows a word sets a sticky UNDERRUN flag.
module oserdes_stream_tx #(
    parameter int   LANES     = 4,
    parameter int   RATIO     = 8,
    parameter bit   MSB_FIRST = 1'b0,
    parameter logic INIT_OQ   = 1'b0,
    parameter logic INIT_TQ   = 1'b1
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [LANES*RATIO-1:0] IN_DATA,
    input  logic [LANES-1:0]       IN_T,
    output logic [LANES-1:0]       OQ,
    output logic [LANES-1:0]       TQ,
    output logic                   WORD_START,
    output logic                   BUSY,
    output logic                   UNDERRUN,
    input  logic                   CLR_UNDERRUN
);

    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    logic [LANES*RATIO-1:0] hold_data;
    logic [LANES-1:0]       hold_t;
    logic                   hold_valid;

    logic [LANES*RATIO-1:0] sh_data;
    logic [LANES-1:0]       sh_t;
    logic                   active;
    logic [CNT_W-1:0]       cnt;

    logic                   underrun_q;

    logic                   end_word;
    logic                   load;
    logic                   handshake;
    logic [CNT_W-1:0]       bit_idx;
    logic [RATIO-1:0]       lane_word [LANES];

    // The shifter takes the held word when it is idle or on its last bit.
    // IN_READY depends only on registered state, never on IN_VALID.
    always_comb begin
        end_word  = active && (cnt == LAST_CNT);
        load      = hold_valid && (!active || end_word);
        IN_READY  = !hold_valid || load;
        handshake = IN_VALID && IN_READY;
    end

    // The holding register captures IN_* only on a handshake. It empties
    // when its word moves into the shifter and no new word replaces it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_t     <= '0;
        end else if (handshake) begin
            hold_valid <= 1'b1;
            hold_data  <= IN_DATA;
            hold_t     <= IN_T;
        end else if (load) begin
            hold_valid <= 1'b0;
        end
    end

    // The shifter walks cnt through 0..RATIO-1 for each word. It then
    // either chains straight into the next held word or drops back to idle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sh_data <= '0;
            sh_t    <= '0;
            active  <= 1'b0;
            cnt     <= '0;
        end else if (load) begin
            sh_data <= hold_data;
            sh_t    <= hold_t;
            active  <= 1'b1;
            cnt     <= '0;
        end else if (end_word) begin
            active  <= 1'b0;
            cnt     <= '0;
        end else if (active) begin
            cnt     <= cnt + 1'b1;
        end
    end

    // The underrun flag is sticky. If a set and a clear land on the same
    // edge, the set wins so that the event is not lost.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            underrun_q <= 1'b0;
        end else if (end_word && !load) begin
            underrun_q <= 1'b1;
        end else if (CLR_UNDERRUN) begin
            underrun_q <= 1'b0;
        end
    end

    // Lane outputs are decoded from the shifter registers only. Reset clears
    // the active flag, so the idle levels appear as soon as reset asserts.
    always_comb begin
        bit_idx = MSB_FIRST ? (LAST_CNT - cnt) : cnt;
        for (int l = 0; l < LANES; l++) begin
            lane_word[l] = sh_data[l*RATIO +: RATIO];
            if (active) begin
                OQ[l] = lane_word[l][bit_idx];
                TQ[l] = sh_t[l];
            end else begin
                OQ[l] = INIT_OQ;
                TQ[l] = INIT_TQ;
            end
        end
        WORD_START = active && (cnt == '0);
        BUSY       = active;
        UNDERRUN   = underrun_q;
    end

endmodule

// File: tb/tb_oserdes_stream_tx.sv
// Self-checking bench for oserdes_stream_tx.
// The main instance (4 lanes, 8:1, LSB first) is tracked by a word-queue
// model that counts down the bits remaining in each word. A second instance
// (1 lane, 8:1, MSB first) gets directed checks of its bit order.
module tb_oserdes_stream_tx;

    localparam int RATIO = 8;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  t;
    } word_t;

    logic        CLK;
    logic        RST_N;

    logic        inValid;
    logic        inReady;
    logic [31:0] inData;
    logic [3:0]  inT;
    logic [3:0]  oq;
    logic [3:0]  tq;
    logic        wordStart;
    logic        busy;
    logic        underrun;
    logic        clrUnderrun;

    logic        bValid;
    logic        bReady;
    logic [7:0]  bData;
    logic [0:0]  bT;
    logic [0:0]  bOq;
    logic [0:0]  bTq;
    logic        bWordStart;
    logic        bBusy;
    logic        bUnderrun;
    logic        bClr;

    int          nVectors;
    int          nMiscompares;

    word_t       holdQ[$];
    word_t       cur;
    int          remaining;
    logic        expUnderrun;

    oserdes_stream_tx #(
        .LANES(4), .RATIO(RATIO), .MSB_FIRST(1'b0), .INIT_OQ(1'b0), .INIT_TQ(1'b1)
    ) dutA (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(inValid), .IN_READY(inReady),
        .IN_DATA(inData), .IN_T(inT), .OQ(oq), .TQ(tq), .WORD_START(wordStart),
        .BUSY(busy), .UNDERRUN(underrun), .CLR_UNDERRUN(clrUnderrun)
    );

    oserdes_stream_tx #(
        .LANES(1), .RATIO(RATIO), .MSB_FIRST(1'b1), .INIT_OQ(1'b0), .INIT_TQ(1'b1)
    ) dutB (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(bValid), .IN_READY(bReady),
        .IN_DATA(bData), .IN_T(bT), .OQ(bOq), .TQ(bTq), .WORD_START(bWordStart),
        .BUSY(bBusy), .UNDERRUN(bUnderrun), .CLR_UNDERRUN(bClr)
    );

    // Free-running serial bit clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVectors++;
        assert (obs === exp) else begin
            nMiscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic expReady();
        return (holdQ.size() == 0) || (remaining <= 1);
    endfunction

    function automatic logic [3:0] expOq();
        logic [3:0] r;
        int p;
        r = 4'b0000;
        if (remaining > 0) begin
            p = RATIO - remaining;
            for (int l = 0; l < 4; l++) r[l] = cur.data[l*RATIO + p];
        end
        return r;
    endfunction

    task automatic modelReset();
        holdQ.delete();
        remaining   = 0;
        expUnderrun = 1'b0;
    endtask

    task automatic modelEdge(input logic hs, input logic [31:0] d, input logic [3:0] t,
                             input logic clr);
        logic lastBit;
        logic setU;
        word_t w;
        lastBit = (remaining == 1);
        setU    = 1'b0;
        if (remaining > 0) remaining--;
        if (remaining == 0 && holdQ.size() > 0) begin
            cur       = holdQ.pop_front();
            remaining = RATIO;
        end else if (lastBit) begin
            setU = 1'b1;
        end
        if (hs) begin
            w.data = d;
            w.t    = t;
            holdQ.push_back(w);
        end
        if (setU) expUnderrun = 1'b1;
        else if (clr) expUnderrun = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, ".oq"}, 32'(oq), 32'(expOq()));
        chk({tag, ".tq"}, 32'(tq), (remaining > 0) ? 32'(cur.t) : 32'hF);
        chk({tag, ".ws"}, 32'(wordStart), 32'(remaining == RATIO));
        chk({tag, ".busy"}, 32'(busy), 32'(remaining > 0));
        chk({tag, ".underrun"}, 32'(underrun), 32'(expUnderrun));
    endtask

    // Drive one cycle of inputs, check ready before the edge, advance the
    // model at the edge and check the registered outputs just after it.
    task automatic applyStimulus(input string tag, input logic v, input logic [31:0] d,
                                 input logic [3:0] t, input logic clr, output logic hs);
        inValid     = v;
        inData      = d;
        inT         = t;
        clrUnderrun = clr;
        #1;
        chk({tag, ".ready"}, 32'(inReady), 32'(expReady()));
        hs = v && expReady();
        @(posedge CLK);
        modelEdge(hs, d, t, clr);
        #1;
        checkOutput(tag);
    endtask

    // Directed scenarios first, then a randomized stream against the model.
    initial begin
        logic        hs;
        logic [7:0]  seq;
        logic [31:0] words [3];
        int          idx;
        int          busyCycles;
        logic        seenBusy;
        logic        wentIdle;
        logic        sawGap;

        nVectors     = 0;
        nMiscompares = 0;
        inValid = 0; inData = '0; inT = '0; clrUnderrun = 0;
        bValid  = 0; bData  = '0; bT  = '0; bClr        = 0;
        modelReset();
        RST_N = 1'b0;
        #3;
        chk("rst.oq", 32'(oq), 32'h0);
        chk("rst.tq", 32'(tq), 32'hF);
        chk("rst.ready", 32'(inReady), 32'h1);
        chk("rst.busy", 32'(busy), 32'h0);
        chk("rst.underrun", 32'(underrun), 32'h0);
        chk("rstB.ready", 32'(bReady), 32'h1);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        $display("[TB] idle after reset release");
        for (int i = 0; i < 20; i++) applyStimulus("idle", 0, 32'h0, 4'h0, 0, hs);

        $display("[TB] single word A5, LSB first");
        applyStimulus("a5.acc", 1, 32'h0000_00A5, 4'h0, 0, hs);
        seq = '0;
        for (int i = 0; i < RATIO; i++) begin
            applyStimulus("a5.bit", 0, 32'h0, 4'h0, 0, hs);
            seq = {oq[0], seq[7:1]};
        end
        chk("a5.seq", 32'(seq), 32'hA5);
        applyStimulus("a5.end", 0, 32'h0, 4'h0, 0, hs);
        chk("a5.underrun", 32'(underrun), 32'h1);

        $display("[TB] single word F0, MSB first");
        bValid = 1; bData = 8'hF0; bT = 1'b0;
        #1;
        chk("f0.ready", 32'(bReady), 32'h1);
        applyStimulus("f0.acc", 0, 32'h0, 4'h0, 0, hs);
        bValid = 0; bData = 8'h00;
        seq = '0;
        for (int i = 0; i < RATIO; i++) begin
            applyStimulus("f0.bit", 0, 32'h0, 4'h0, 0, hs);
            seq = {seq[6:0], bOq[0]};
            chk("f0.ws", 32'(bWordStart), 32'(i == 0));
            chk("f0.tq", 32'(bTq), 32'h0);
        end
        chk("f0.seq", 32'(seq), 32'hF0);
        applyStimulus("f0.end", 0, 32'h0, 4'h0, 0, hs);
        chk("f0.underrun", 32'(bUnderrun), 32'h1);
        chk("f0.idle", 32'(bTq), 32'h1);

        $display("[TB] continuous stream of three words");
        words[0] = 32'h01; words[1] = 32'h02; words[2] = 32'h03;
        idx = 0; busyCycles = 0; seenBusy = 0; wentIdle = 0; sawGap = 0;
        for (int c = 0; c < 60; c++) begin
            if (idx < 3) applyStimulus("stream", 1, words[idx], 4'h0, c == 0, hs);
            else         applyStimulus("stream", 0, 32'h0, 4'h0, 0, hs);
            if (hs) idx++;
            if (busy) begin
                busyCycles++;
                if (wentIdle) sawGap = 1;
                seenBusy = 1;
            end else if (seenBusy) begin
                wentIdle = 1;
            end
        end
        chk("stream.accepted", 32'(idx), 32'd3);
        chk("stream.busyCycles", 32'(busyCycles), 32'd24);
        chk("stream.gap", 32'(sawGap), 32'h0);

        $display("[TB] tristate pattern and set-over-clear");
        applyStimulus("tri.acc", 1, 32'hFFFF_FFFF, 4'b0101, 1, hs);
        for (int i = 0; i < RATIO; i++) begin
            applyStimulus("tri.bit", 0, 32'h0, 4'h0, 0, hs);
            chk("tri.tq", 32'(tq), 32'h5);
        end
        applyStimulus("tri.end", 0, 32'h0, 4'h0, 1, hs);
        chk("tri.underrunKept", 32'(underrun), 32'h1);
        chk("tri.tqIdle", 32'(tq), 32'hF);

        $display("[TB] reset in the middle of a word");
        applyStimulus("mid.accA", 1, 32'hDEAD_BEEF, 4'b0011, 0, hs);
        applyStimulus("mid.accB", 1, 32'h1234_5678, 4'b1100, 0, hs);
        for (int i = 0; i < 3; i++) applyStimulus("mid.run", 0, 32'h0, 4'h0, 0, hs);
        inValid = 0;
        #2;
        RST_N = 1'b0;
        modelReset();
        #1;
        chk("mid.oq", 32'(oq), 32'h0);
        chk("mid.tq", 32'(tq), 32'hF);
        chk("mid.busy", 32'(busy), 32'h0);
        chk("mid.ready", 32'(inReady), 32'h1);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 12; i++) applyStimulus("mid.after", 0, 32'h0, 4'h0, 0, hs);

        $display("[TB] randomized stream");
        for (int c = 0; c < 400; c++) begin
            applyStimulus("rand", ($urandom_range(0, 9) < 7), $urandom,
                          4'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0), hs);
        end
        for (int i = 0; i < 20; i++) applyStimulus("drain", 0, 32'h0, 4'h0, 0, hs);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
